// File: rtl/mask_index_encoder.sv
// Sequential mask-to-index encoder: emits the index of every set bit of an
// accepted mask, one per beat, with valid/ready on both sides.
// Ports: clk, rst_n; i/i_valid/i_ready (mask in); o/o_valid/o_ready/o_last/o_none (beats out).
module mask_index_encoder #(
  parameter int N         = 8,
  parameter int IW        = 3,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i,
  input  logic          i_valid,
  output logic          i_ready,
  output logic [IW-1:0] o,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          o_last,
  output logic          o_none
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  pend_q, pend_d;
  logic          irdy_q, irdy_d;
  logic          ov_q, ov_d;
  logic [IW-1:0] o_q, o_d;
  logic          last_q, last_d;
  logic          none_q, none_d;
  logic [N-1:0]  oh;
  logic [N-1:0]  nxt;

  // Scan direction decides which set bit wins.
  function automatic logic [IW-1:0] first_idx(input logic [N-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    if (LSB_FIRST) begin
      for (int p = N - 1; p >= 0; p--)
        if (m[p]) r = p[IW-1:0];
    end else begin
      for (int p = 0; p < N; p++)
        if (m[p]) r = p[IW-1:0];
    end
    return r;
  endfunction

  // m & (m-1) strips the lowest set bit; zero means popcount <= 1.
  function automatic logic at_most_one(input logic [N-1:0] m);
    return (m & (m - {{(N-1){1'b0}}, 1'b1})) == '0;
  endfunction

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    irdy_d  = irdy_q;
    ov_d    = ov_q;
    o_d     = o_q;
    last_d  = last_q;
    none_d  = none_q;
    oh      = '0;
    oh[o_q] = 1'b1;
    nxt     = pend_q & ~oh;
    unique case (state_q)
      IDLE: begin
        irdy_d = 1'b1;
        if (i_valid && irdy_q) begin
          state_d = EMIT;
          pend_d  = i;
          irdy_d  = 1'b0;
          ov_d    = 1'b1;
          o_d     = first_idx(i);
          last_d  = at_most_one(i);
          none_d  = (i == '0);
        end
      end
      EMIT: begin
        if (o_ready) begin
          pend_d = nxt;
          none_d = 1'b0;
          if (last_q) begin
            state_d = IDLE;
            irdy_d  = 1'b1;
            ov_d    = 1'b0;
            o_d     = '0;
            last_d  = 1'b0;
          end else begin
            o_d    = first_idx(nxt);
            last_d = at_most_one(nxt);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      irdy_q  <= 1'b0;
      ov_q    <= 1'b0;
      o_q     <= '0;
      last_q  <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      irdy_q  <= irdy_d;
      ov_q    <= ov_d;
      o_q     <= o_d;
      last_q  <= last_d;
      none_q  <= none_d;
    end
  end

  assign i_ready = irdy_q;
  assign o_valid = ov_q;
  assign o       = o_q;
  assign o_last  = last_q;
  assign o_none  = none_q;

endmodule

// File: tb/tb_mask_index_encoder.sv
// Bench for mask_index_encoder: LSB-first and MSB-first instances share
// stimulus; expected beats are queued at acceptance and popped per transfer.
module tb_mask_index_encoder;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic       none;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] i = '0;
  logic       i_valid = 1'b0;
  logic       o_ready = 1'b0;

  logic       ir_l, ov_l, la_l, no_l;
  logic [2:0] o_l;
  logic       ir_m, ov_m, la_m, no_m;
  logic [2:0] o_m;

  int checks = 0;
  int failures = 0;
  beat_t ql[$];
  beat_t qm[$];

  always #5 clk = ~clk;

  mask_index_encoder #(.N(8), .IW(3), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .i(i), .i_valid(i_valid), .i_ready(ir_l),
    .o(o_l), .o_valid(ov_l), .o_ready(o_ready), .o_last(la_l), .o_none(no_l)
  );

  mask_index_encoder #(.N(8), .IW(3), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .i(i), .i_valid(i_valid), .i_ready(ir_m),
    .o(o_m), .o_valid(ov_m), .o_ready(o_ready), .o_last(la_m), .o_none(no_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] m);
    int cnt;
    int n;
    logic [2:0] p3;
    cnt = $countones(m);
    if (m == 8'h00) begin
      ql.push_back('{3'd0, 1'b1, 1'b1});
      qm.push_back('{3'd0, 1'b1, 1'b1});
    end else begin
      n = 0;
      for (int p = 0; p < 8; p++) if (m[p]) begin
        n++;
        p3 = 3'(p);
        ql.push_back('{p3, n == cnt, 1'b0});
      end
      n = 0;
      for (int p = 7; p >= 0; p--) if (m[p]) begin
        n++;
        p3 = 3'(p);
        qm.push_back('{p3, n == cnt, 1'b0});
      end
    end
  endtask

  task automatic cmp_front(input string tag);
    chk({tag, "_lsb"}, {26'd0, ov_l, no_l, la_l, o_l},
        {26'd0, 1'b1, ql[0].none, ql[0].last, ql[0].idx});
    chk({tag, "_msb"}, {26'd0, ov_m, no_m, la_m, o_m},
        {26'd0, 1'b1, qm[0].none, qm[0].last, qm[0].idx});
  endtask

  task automatic send(input logic [7:0] m);
    int w;
    w = 0;
    while (!ir_l && w < 50) begin
      step();
      w++;
    end
    chk("irdy_wait", {31'd0, ir_l}, 32'd1);
    i = m;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    push_exp(m);
    chk("accept_lat", {30'd0, ov_l, ir_l}, 32'd2);
  endtask

  task automatic drain(input int stall);
    o_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      cmp_front("hold");
      step();
    end
    o_ready = 1'b1;
    for (int b = 0; b < 20 && ql.size() > 0; b++) begin
      cmp_front("beat");
      step();
      void'(ql.pop_front());
      if (qm.size() > 0) void'(qm.pop_front());
    end
    chk("drain_done", ql.size(), 32'd0);
    chk("turnaround", {29'd0, ir_l, ir_m, ov_l}, 32'd6);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_lsb", {25'd0, ir_l, ov_l, la_l, no_l, o_l}, 32'd0);
    chk("rst_msb", {25'd0, ir_m, ov_m, la_m, no_m, o_m}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("irdy_pre", {31'd0, ir_l}, 32'd0);
    step();
    chk("irdy_post", {30'd0, ir_l, ir_m}, 32'd3);

    send(8'b0010_0101);
    drain(0);
    send(8'h00);
    drain(0);
    send(8'h81);
    drain(3);
    send(8'hFF);
    drain(0);

    // new mask held on i_valid throughout EMIT
    send(8'h81);
    i = 8'h3C;
    i_valid = 1'b1;
    drain(1);
    step();
    i_valid = 1'b0;
    push_exp(8'h3C);
    chk("held_accept", {31'd0, ov_l}, 32'd1);
    drain(0);

    // reset after two beats of a full mask
    send(8'hFF);
    o_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      cmp_front("pre_rst");
      step();
      void'(ql.pop_front());
      void'(qm.pop_front());
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_lsb", {25'd0, ir_l, ov_l, la_l, no_l, o_l}, 32'd0);
    chk("midrst_msb", {25'd0, ir_m, ov_m, la_m, no_m, o_m}, 32'd0);
    ql.delete();
    qm.delete();
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rel_ovalid", {30'd0, ov_l, ov_m}, 32'd0);
    step();
    chk("rel_irdy", {31'd0, ir_l}, 32'd1);
    send(8'h10);
    drain(0);

    for (int r = 0; r < 4; r++) begin
      send(8'($urandom_range(0, 255)));
      drain(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
